// File: rtl/multicycle_hart_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_hart_if : memory bus between the hart and its memory          |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface multicycle_hart_if;
  logic [31:0] mem_addr;
  logic        mem_wenable;
  logic [1:0]  mem_wwidth;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output mem_addr, mem_wenable, mem_wwidth, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wenable, mem_wwidth, mem_wdata,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_hart.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_hart : multicycle RV32I-subset core with fixed-latency reads  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module multicycle_hart #(
  parameter int unsigned READ_LATENCY = 2,
  parameter logic [31:0] RESET_VECTOR = 32'h0,
  parameter logic [31:0] STACK_START  = 32'hc00
) (
  input  logic                     clock,
  input  logic                     reset,
  multicycle_hart_if.master        mem,
  output logic [31:0]              pc,
  output logic                     retire,
  output logic                     halted,
  input  logic [4:0]               dbg_sel,
  output logic [31:0]              dbg_val
);

  localparam logic [3:0] LAT        = READ_LATENCY[3:0];
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {FETCH, LOAD, WRITEBACK, HALT} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, ld_q, ld_d;
  logic        retire_q, retire_d, halted_q, halted_d;
  logic [31:0] xregs_q [32];

  function automatic logic legal(input logic [31:0] ins);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = ins[14:12];
    f7 = ins[31:25];
    case (ins[6:0])
      OPC_LUI, OPC_AUIPC, OPC_JAL: legal = 1'b1;
      OPC_JALR:   legal = (f3 == 3'd0);
      OPC_BRANCH: legal = (f3 != 3'd2) && (f3 != 3'd3);
      OPC_LOAD:   legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
      OPC_STORE:  legal = (f3 <= 3'd2);
      OPC_OPIMM:  legal = (f3 == 3'd1) ? (f7 == 7'h00) :
                          (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
      OPC_OP:     legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      default:    legal = 1'b0;
    endcase
  endfunction

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [31:0] rs1_v, rs2_v, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] alu_b, alu_r, ld_ext, rd_val, target, next_pc;
  logic        rd_wr, jump, take, misaligned, wen;

  assign opc   = instr_q[6:0];
  assign f3    = instr_q[14:12];
  assign rd    = instr_q[11:7];
  assign rs1_v = xregs_q[instr_q[19:15]];
  assign rs2_v = xregs_q[instr_q[24:20]];
  assign imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_u = {instr_q[31:12], 12'h000};
  assign imm_j = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
  assign alu_b = (opc == OPC_OP) ? rs2_v : imm_i;

  always_comb begin
    alu_r = 32'h0;
    case (f3)
      3'd0: alu_r = (opc == OPC_OP && instr_q[30]) ? rs1_v - alu_b : rs1_v + alu_b;
      3'd1: alu_r = rs1_v << alu_b[4:0];
      3'd2: alu_r = {31'h0, $signed(rs1_v) < $signed(alu_b)};
      3'd3: alu_r = {31'h0, rs1_v < alu_b};
      3'd4: alu_r = rs1_v ^ alu_b;
      3'd5: alu_r = instr_q[30] ? 32'($signed(rs1_v) >>> alu_b[4:0]) : rs1_v >> alu_b[4:0];
      3'd6: alu_r = rs1_v | alu_b;
      default: alu_r = rs1_v & alu_b;
    endcase
  end

  always_comb begin
    ld_ext = ld_q;
    case (f3)
      3'd0: ld_ext = {{24{ld_q[7]}}, ld_q[7:0]};
      3'd1: ld_ext = {{16{ld_q[15]}}, ld_q[15:0]};
      3'd4: ld_ext = {24'h0, ld_q[7:0]};
      3'd5: ld_ext = {16'h0, ld_q[15:0]};
      default: ld_ext = ld_q;
    endcase
  end

  always_comb begin
    take = 1'b0;
    case (f3)
      3'd0: take = (rs1_v == rs2_v);
      3'd1: take = (rs1_v != rs2_v);
      3'd4: take = $signed(rs1_v) < $signed(rs2_v);
      3'd5: take = $signed(rs1_v) >= $signed(rs2_v);
      3'd6: take = rs1_v < rs2_v;
      3'd7: take = rs1_v >= rs2_v;
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    rd_val = alu_r;
    rd_wr  = 1'b1;
    jump   = 1'b0;
    target = pc_q + imm_b;
    case (opc)
      OPC_LUI:    rd_val = imm_u;
      OPC_AUIPC:  rd_val = pc_q + imm_u;
      OPC_JAL:    begin rd_val = pc_q + 32'd4; jump = 1'b1; target = pc_q + imm_j; end
      OPC_JALR:   begin rd_val = pc_q + 32'd4; jump = 1'b1; target = (rs1_v + imm_i) & ~32'd1; end
      OPC_BRANCH: begin rd_wr = 1'b0; jump = take; end
      OPC_LOAD:   rd_val = ld_ext;
      OPC_STORE:  rd_wr = 1'b0;
      default:    rd_val = alu_r;
    endcase
    next_pc    = jump ? target : pc_q + 32'd4;
    misaligned = jump && (target[1:0] != 2'b00);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    ld_d     = ld_q;
    retire_d = 1'b0;
    halted_d = halted_q;
    wen      = 1'b0;
    mem.mem_addr   = pc_q;
    mem.mem_wwidth = f3[1:0];
    mem.mem_wdata  = rs2_v;
    case (state_q)
      FETCH: begin
        if (cnt_q == 4'd0) begin
          instr_d = mem.mem_rdata;
          cnt_d   = LAT;
          if (!legal(mem.mem_rdata)) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end else if (mem.mem_rdata[6:0] == OPC_LOAD) begin
            state_d = LOAD;
          end else begin
            state_d = WRITEBACK;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      LOAD: begin
        mem.mem_addr = rs1_v + imm_i;
        if (cnt_q == 4'd0) begin
          ld_d    = mem.mem_rdata;
          cnt_d   = LAT;
          state_d = WRITEBACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WRITEBACK: begin
        if (opc == OPC_STORE) begin
          mem.mem_addr = rs1_v + imm_s;
          wen          = 1'b1;
        end
        // A misaligned taken target leaves pc on the faulting instruction.
        if (misaligned) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else begin
          pc_d     = next_pc;
          retire_d = 1'b1;
          state_d  = FETCH;
        end
      end
      default: state_d = HALT;
    endcase
  end

  assign mem.mem_wenable = wen & reset;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= FETCH;
      cnt_q    <= LAT;
      pc_q     <= RESET_VECTOR;
      instr_q  <= 32'h0;
      ld_q     <= 32'h0;
      retire_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      ld_q     <= ld_d;
      retire_q <= retire_d;
      halted_q <= halted_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        xregs_q[i] <= (i == 2) ? STACK_START : 32'h0;
      end
    end else if (state_q == WRITEBACK && !misaligned && rd_wr && rd != 5'd0) begin
      xregs_q[rd] <= rd_val;
    end
  end

  assign pc      = pc_q;
  assign retire  = retire_q;
  assign halted  = halted_q;
  assign dbg_val = (dbg_sel == 5'd0) ? 32'h0 : xregs_q[dbg_sel];

endmodule
`default_nettype wire

// File: tb/tb_multicycle_hart.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_multicycle_hart : directed self-checking bench for multicycle_hart    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_multicycle_hart;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  dbg_sel = 5'd0;
  logic [31:0] pc, dbg_val;
  logic        retire, halted;

  multicycle_hart_if bus ();

  multicycle_hart #(.READ_LATENCY(2), .RESET_VECTOR(32'h0), .STACK_START(32'hc00)) dut (
    .clock(clk), .reset(rst_n), .mem(bus.master), .pc(pc), .retire(retire),
    .halted(halted), .dbg_sel(dbg_sel), .dbg_val(dbg_val)
  );

  always #5 clk = ~clk;

  // Memory returns garbage until the address has been stable for 2 cycles.
  logic [31:0] mem [128];
  logic [31:0] last_addr = 32'hFFFF_FFFF;
  int          age = 0;
  always @(posedge clk) begin
    age       <= (bus.mem_addr == last_addr) ? age + 1 : 1;
    last_addr <= bus.mem_addr;
  end
  always_comb begin
    bus.mem_rdata = 32'hDEAD_BEEF;
    if (bus.mem_addr == last_addr && age >= 2) bus.mem_rdata = mem[bus.mem_addr[8:2]];
  end

  int n_chk = 0, n_pass = 0;
  int cyc, n_ret, n_stb;
  int ret_at [8];
  logic [31:0] stb_addr, stb_data;
  logic [1:0]  stb_w;
  logic [31:0] x4a;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
    dbg_sel = idx;
    #1;
    chk(tag, dbg_val, exp);
  endtask

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
  endtask

  // Leaves the bench 1 time unit into the first cycle after reset release.
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0; n_ret = 0; n_stb = 0;
    stb_addr = 32'h0; stb_data = 32'h0; stb_w = 2'd0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (retire) begin
        if (n_ret < 8) ret_at[n_ret] = cyc;
        n_ret++;
      end
      if (bus.mem_wenable) begin
        n_stb++;
        stb_addr = bus.mem_addr; stb_data = bus.mem_wdata; stb_w = bus.mem_wwidth;
      end
    end
  endtask

  initial begin
    clear_mem();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_retire", {31'h0, retire}, 32'd0);
    chk("rst_halted", {31'h0, halted}, 32'd0);
    chk("rst_wen", {31'h0, bus.mem_wenable}, 32'd0);
    chk_reg("rst_x2", 5'd2, 32'h0000_0c00);
    chk_reg("rst_x1", 5'd1, 32'h0);

    // addi chain, retire cadence, x0 discard
    clear_mem();
    mem[0] = enc_i(32'd5, 5'd0, 3'd0, 5'd1, 7'h13);
    mem[1] = enc_i(-32'sd7, 5'd1, 3'd0, 5'd1, 7'h13);
    mem[2] = enc_i(32'd5, 5'd0, 3'd0, 5'd0, 7'h13);
    mem[3] = 32'hFFFF_FFFF;
    do_reset();
    run(20);
    chk_reg("addi_x1", 5'd1, 32'hFFFF_FFFE);
    chk_reg("x0_zero", 5'd0, 32'h0);
    chk("addi_first_ret", 32'(ret_at[0]), 32'd4);
    chk("addi_period", 32'(ret_at[1] - ret_at[0]), 32'd4);
    chk("addi_nret", 32'(n_ret), 32'd3);
    chk("addi_halt_pc", pc, 32'hC);

    // loads with sign/zero extension
    clear_mem();
    mem[0]  = enc_i(32'h100, 5'd0, 3'd0, 5'd1, 7'h03);
    mem[1]  = enc_i(32'h100, 5'd0, 3'd4, 5'd2, 7'h03);
    mem[2]  = enc_i(32'h100, 5'd0, 3'd1, 5'd3, 7'h03);
    mem[3]  = enc_i(32'h100, 5'd0, 3'd5, 5'd4, 7'h03);
    mem[4]  = 32'hFFFF_FFFF;
    mem[64] = 32'h0000_80F0;
    do_reset();
    run(40);
    chk_reg("lb", 5'd1, 32'hFFFF_FFF0);
    chk_reg("lbu", 5'd2, 32'h0000_00F0);
    chk_reg("lh", 5'd3, 32'hFFFF_80F0);
    chk_reg("lhu", 5'd4, 32'h0000_80F0);
    chk("ld_first_ret", 32'(ret_at[0]), 32'd7);
    chk("ld_period", 32'(ret_at[1] - ret_at[0]), 32'd7);
    chk("ld_period2", 32'(ret_at[3] - ret_at[2]), 32'd7);

    // halfword store
    clear_mem();
    mem[0] = {20'h12345, 5'd5, 7'h37};
    mem[1] = enc_i(32'h678, 5'd5, 3'd0, 5'd5, 7'h13);
    mem[2] = enc_s(32'd2, 5'd5, 5'd0, 3'd1);
    mem[3] = 32'hFFFF_FFFF;
    do_reset();
    run(30);
    chk_reg("sh_x5", 5'd5, 32'h1234_5678);
    chk("sh_nstb", 32'(n_stb), 32'd1);
    chk("sh_addr", stb_addr, 32'd2);
    chk("sh_width", {30'h0, stb_w}, 32'd1);
    chk("sh_data", stb_data, 32'h1234_5678);

    // signed vs unsigned branch, then misaligned jalr
    clear_mem();
    mem[0] = enc_i(-32'sd1, 5'd0, 3'd0, 5'd1, 7'h13);
    mem[1] = enc_i(32'd1, 5'd0, 3'd0, 5'd2, 7'h13);
    mem[2] = enc_b(32'd8, 5'd2, 5'd1, 3'd4);
    mem[3] = 32'hFFFF_FFFF;
    mem[4] = enc_b(32'd12, 5'd2, 5'd1, 3'd6);
    mem[5] = enc_i(32'h102, 5'd0, 3'd0, 5'd3, 7'h13);
    mem[6] = enc_i(32'd0, 5'd3, 3'd0, 5'd1, 7'h67);
    mem[7] = 32'hFFFF_FFFF;
    do_reset();
    run(40);
    chk("br_halted", {31'h0, halted}, 32'd1);
    chk("br_pc", pc, 32'h18);
    chk_reg("jalr_x1", 5'd1, 32'hFFFF_FFFF);
    chk_reg("br_x3", 5'd3, 32'h102);
    chk("br_nret", 32'(n_ret), 32'd5);

    // jal loop
    clear_mem();
    mem[0] = enc_i(32'd1, 5'd4, 3'd0, 5'd4, 7'h13);
    mem[1] = enc_j(-32'sd4, 5'd0);
    do_reset();
    run(12);
    chk_reg("loop_x4_a", 5'd4, 32'd2);
    run(8);
    chk_reg("loop_x4_b", 5'd4, 32'd3);
    chk("loop_halted", {31'h0, halted}, 32'd0);

    // reset during store writeback
    clear_mem();
    mem[0] = enc_i(32'h55, 5'd0, 3'd0, 5'd2, 7'h13);
    mem[1] = enc_s(32'h40, 5'd0, 5'd0, 3'd2);
    do_reset();
    run(7);
    chk("st_wen_pre", {31'h0, bus.mem_wenable}, 32'd1);
    chk("st_addr_pre", bus.mem_addr, 32'h40);
    chk_reg("st_x2_pre", 5'd2, 32'h55);
    rst_n = 1'b0;
    #1;
    chk("st_wen_gated", {31'h0, bus.mem_wenable}, 32'd0);
    @(posedge clk);
    #1;
    chk("st_rst_pc", pc, 32'h0);
    chk_reg("st_rst_x2", 5'd2, 32'h0000_0c00);

    // unsupported instruction
    clear_mem();
    mem[0] = enc_i(32'd1, 5'd0, 3'd0, 5'd1, 7'h13);
    mem[1] = enc_i(32'd1, 5'd1, 3'd0, 5'd1, 7'h13);
    mem[2] = 32'hFFFF_FFFF;
    do_reset();
    run(12);
    n_ret = 0;
    run(20);
    chk("ill_nret", 32'(n_ret), 32'd0);
    chk("ill_halted", {31'h0, halted}, 32'd1);
    chk("ill_pc", pc, 32'h8);
    chk_reg("ill_x1", 5'd1, 32'd2);

    do_reset();
    chk("halt_rst", {31'h0, halted}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
